ir_cmd_ctrl: RTL and testbench
==============================

# ir_cmd_ctrl

Command controller between the NEC IR receiver and the snake game engine. It validates each decoded 32-bit NEC frame, maps remote keys to snake directions or a pause toggle, and rejects illegal turns. Accepted turns are queued and released to the game one per movement tick, so the snake never reverses into itself and quick key bursts are not lost.

## Interface

Parameters:
- `ADDR`, 8'h00: expected NEC remote address.
- `DEPTH`, 2: direction queue depth, ≥1.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `word`  in  32  NEC frame from receiver: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- `frame_valid`  in  1  one-cycle pulse; `word` is valid in that cycle.
- `tick`  in  1  one-cycle game movement strobe.
- `heading`  out  2  current direction: UP=0, RIGHT=1, DOWN=2, LEFT=3.
- `turn`  out  1  one-cycle pulse when `heading` changes.
- `paused`  out  1  game pause state.
- `last_cmd`  out  8  cmd byte of the last valid frame, for the 7-seg display.
- `err_count`  out  8  count of rejected frames, saturating.

## Operation

- Stage 1 (CAPTURE): on `frame_valid`, register `word` and set the internal pending flag.
- Stage 2 (EVAL): one cycle after capture, evaluate the registered frame. The pipeline accepts `frame_valid` every cycle and never stalls.
- Frame is valid iff addr == `ADDR`, addr ^ ~addr == 8'hFF, and cmd ^ ~cmd == 8'hFF.
  - Invalid frame: `err_count` += 1, saturating at 255. No other effect.
  - Valid frame: `last_cmd` <= cmd.
- Key map for valid frames:
  - 8'h18 → UP.
  - 8'h5A → RIGHT.
  - 8'h52 → DOWN.
  - 8'h08 → LEFT.
  - 8'h1C → PAUSE.
  - Any other cmd is ignored and is not an error.
- PAUSE toggles `paused`. Entering pause flushes the queue. Leaving pause does not touch the queue.
- Direction key:
  - Reference direction = queue tail if the queue is non-empty, else `heading`.
  - Drop the key if it is paused, equals the reference, or is the opposite of the reference (opposite = dir ^ 2'b10).
  - Drop the key if the queue is full; the newest key is discarded.
  - Otherwise push it.
- On `tick` with `paused` = 0 and queue non-empty: pop, `heading` <= popped value, `turn` = 1 for one cycle.
  - `tick` while paused or with an empty queue: no effect.

## Timing

- Reset values:
  - `heading` = RIGHT (1).
  - `turn` = 0, `paused` = 0.
  - `last_cmd` = 8'h00, `err_count` = 8'h00.
  - Queue empty, capture stage empty.
- Latency: `frame_valid` in cycle N → `last_cmd`, `err_count`, `paused` and queue contents update at the N+2 edge.
- `tick` in cycle T → `heading` and `turn` valid in T+1. `turn` deasserts in T+2 unless another pop occurs.
- Same-cycle push and pop:
  - Both take effect.
  - The turn filter uses the pre-pop tail.
  - A push into an empty queue coinciding with `tick` is not popped by that tick.
  - A full queue popping and pushing in the same cycle still drops the push; fullness is judged pre-pop.
- Same-cycle PAUSE-enter and `tick`: the pause wins, the queue is flushed, and `heading` is unchanged.
- Asynchronous reset mid-frame discards the in-flight capture and evaluation with no side effects.

## Structure

- Package `snake_pkg` holds:
  - `dir_t` enum (UP, RIGHT, DOWN, LEFT).
  - NEC key constants (`KEY_UP`, `KEY_RIGHT`, `KEY_DOWN`, `KEY_LEFT`, `KEY_PAUSE`).
  - `opposite()` function.
- Sub-module `dir_fifo`:
  - Parameter `DEPTH`; `dir_t` entries.
  - Ports: push, pop, flush (flush has priority), full, empty, tail, head.
  - Wrap-around pointers with a separate count.
- `ir_cmd_ctrl` keeps the capture/eval pipeline, the pause flag, the heading register and the counters.

## Test plan

- Reset release → `heading` = 1, `paused` = 0, `turn` = 0, `last_cmd` = 8'h00, `err_count` = 0.
- Frame 32'h00FF18E7 (UP), then `tick` → `heading` = 0 one cycle after the tick, `turn` pulses for exactly 1 cycle, `last_cmd` = 8'h18.
- Heading RIGHT, frame 32'h00FF08F7 (LEFT), then `tick` → `heading` stays 1, no `turn`, `last_cmd` = 8'h08.
- Back-to-back frames UP (00FF18E7), LEFT (00FF08F7), DOWN (00FF52AD) on consecutive cycles, then three ticks:
  - DOWN is dropped because the queue is full.
  - `heading` sequence is 0 → 3 → 3.
  - `turn` pulses twice.
- Frame 32'h00FF18E6 (bad ~cmd) → `err_count` = 1, queue empty. A further 300 bad frames → `err_count` = 255.
- PAUSE sequence:
  - Queue UP, then PAUSE (00FF1CE3) → `paused` = 1, queue flushed.
  - `tick` → `heading` unchanged.
  - UP frame while paused → dropped.
  - PAUSE again → `paused` = 0.
  - `tick` → `heading` unchanged.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the IR command controller.
//   dir_t      : snake direction, encoded UP=0, RIGHT=1, DOWN=2, LEFT=3
//   KEY_*      : NEC command bytes of the remote keys in use
//   opposite() : direction pointing the other way
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_UP    = 8'h18;
    localparam logic [7:0] KEY_RIGHT = 8'h5A;
    localparam logic [7:0] KEY_DOWN  = 8'h52;
    localparam logic [7:0] KEY_LEFT  = 8'h08;
    localparam logic [7:0] KEY_PAUSE = 8'h1C;

    // Encoding puts opposite directions two apart, so flipping bit 1 reverses.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small direction queue between the turn filter and the movement tick.
//   clk, reset_n : clock, async active-low reset (queue empties)
//   push, din    : enqueue din
//   pop          : dequeue head
//   flush        : empty the queue; wins over push and pop
//   full, empty  : occupancy flags
//   tail         : most recently pushed entry (valid when !empty)
//   head         : oldest entry (valid when !empty)
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  dir_t din,
    output logic full,
    output logic empty,
    output dir_t tail,
    output dir_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    dir_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, tail_ptr;
    logic [CW-1:0] count;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
    assign tail     = mem[tail_ptr];
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// Validates NEC frames from the IR receiver and turns them into snake moves.
//   clk, reset_n : 50 MHz clock, async active-low reset
//   word         : NEC frame {addr, ~addr, cmd, ~cmd}
//   frame_valid  : one-cycle strobe qualifying word
//   tick         : game movement strobe; releases one queued turn
//   heading      : current direction (UP=0 RIGHT=1 DOWN=2 LEFT=3)
//   turn         : one-cycle pulse when heading changes
//   paused       : pause state, toggled by the PAUSE key
//   last_cmd     : cmd byte of the most recent valid frame
//   err_count    : saturating count of rejected frames
module ir_cmd_ctrl
    import snake_pkg::*;
#(
    parameter logic [7:0] ADDR  = 8'h00,
    parameter int         DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] word,
    input  logic        frame_valid,
    input  logic        tick,
    output logic [1:0]  heading,
    output logic        turn,
    output logic        paused,
    output logic [7:0]  last_cmd,
    output logic [7:0]  err_count
);

    // Capture stage
    logic        cap_vld;
    logic [31:0] cap_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld  <= 1'b0;
            cap_word <= '0;
        end else begin
            cap_vld <= frame_valid;
            if (frame_valid)
                cap_word <= word;
        end
    end

    // Evaluate stage
    logic [7:0] f_addr, f_addr_n, f_cmd, f_cmd_n;
    logic       frame_ok, frame_bad;

    assign {f_addr, f_addr_n, f_cmd, f_cmd_n} = cap_word;
    assign frame_ok  = cap_vld && (f_addr == ADDR) &&
                       ((f_addr ^ f_addr_n) == 8'hFF) &&
                       ((f_cmd ^ f_cmd_n) == 8'hFF);
    assign frame_bad = cap_vld && !frame_ok;

    logic is_dir;
    dir_t key_dir;

    always_comb begin
        is_dir  = 1'b1;
        key_dir = UP;
        case (f_cmd)
            KEY_UP:    key_dir = UP;
            KEY_RIGHT: key_dir = RIGHT;
            KEY_DOWN:  key_dir = DOWN;
            KEY_LEFT:  key_dir = LEFT;
            default:   is_dir  = 1'b0;
        endcase
    end

    dir_t heading_q;
    logic q_full, q_empty;
    dir_t q_tail, q_head;
    dir_t ref_dir;
    logic pause_key, pause_enter, push, pop;

    assign pause_key   = frame_ok && (f_cmd == KEY_PAUSE);
    assign pause_enter = pause_key && !paused;

    // Filter against the newest pending turn so a burst cannot chain into
    // a reversal; fullness and tail are pre-pop values.
    assign ref_dir = q_empty ? heading_q : q_tail;
    assign push    = frame_ok && is_dir && !paused && !q_full &&
                     (key_dir != ref_dir) && (key_dir != opposite(ref_dir));

    // A PAUSE entering this cycle suppresses the pop so heading holds.
    assign pop = tick && !paused && !q_empty && !pause_enter;

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (pause_enter),
        .din     (key_dir),
        .full    (q_full),
        .empty   (q_empty),
        .tail    (q_tail),
        .head    (q_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            heading_q <= RIGHT;
            turn      <= 1'b0;
            paused    <= 1'b0;
            last_cmd  <= 8'h00;
            err_count <= 8'h00;
        end else begin
            turn <= pop;
            if (pop)
                heading_q <= q_head;
            if (pause_key)
                paused <= !paused;
            if (frame_ok)
                last_cmd <= f_cmd;
            if (frame_bad && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    assign heading = heading_q;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
module tb_ir_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] word = '0;
    logic        frame_valid = 1'b0;
    logic        tick = 1'b0;
    logic [1:0]  heading;
    logic        turn;
    logic        paused;
    logic [7:0]  last_cmd;
    logic [7:0]  err_count;

    ir_cmd_ctrl #(.ADDR(8'h00), .DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .word        (word),
        .frame_valid (frame_valid),
        .tick        (tick),
        .heading     (heading),
        .turn        (turn),
        .paused      (paused),
        .last_cmd    (last_cmd),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] F_UP    = 32'h00FF18E7;
    localparam logic [31:0] F_LEFT  = 32'h00FF08F7;
    localparam logic [31:0] F_DOWN  = 32'h00FF52AD;
    localparam logic [31:0] F_PAUSE = 32'h00FF1CE3;
    localparam logic [31:0] F_BADC  = 32'h00FF18E6;
    localparam logic [31:0] F_BADA  = 32'h01FE18E7;
    localparam logic [31:0] F_BADAN = 32'h00FE18E7;
    localparam logic [31:0] F_OTHER = 32'h00FF45BA;

    // One row = one clock cycle of stimulus; expectations are the outputs
    // seen just after that cycle's rising edge.
    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] w;
        logic        tk;
        logic [1:0]  h;
        logic        tn;
        logic        p;
        logic [7:0]  lc;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic fv, input logic [31:0] w,
                       input logic tk, input logic [1:0] h, input logic tn,
                       input logic p, input logic [7:0] lc, input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.fv = fv; v.w = w; v.tk = tk;
        v.h = h; v.tn = tn; v.p = p; v.lc = lc; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] h, input logic tn,
                           input logic p, input logic [7:0] lc, input logic [7:0] ec);
        chk({tag, " heading"},   32'(heading),   32'(h));
        chk({tag, " turn"},      32'(turn),      32'(tn));
        chk({tag, " paused"},    32'(paused),    32'(p));
        chk({tag, " last_cmd"},  32'(last_cmd),  32'(lc));
        chk({tag, " err_count"}, 32'(err_count), 32'(ec));
    endtask

    task automatic cyc(input logic fv, input logic [31:0] w, input logic tk);
        @(negedge clk);
        reset_n     = 1'b1;
        frame_valid = fv;
        word        = w;
        tick        = tk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //      rst fv word     tk  h  tn p  lc     ec
        // reset, then LEFT while heading RIGHT is an illegal reversal
        add(1, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 1, F_LEFT,  0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h08, 0);
        add(0, 0, 0,       1, 1, 0, 0, 8'h08, 0);
        // UP then tick: one-cycle turn
        add(0, 1, F_UP,    0, 1, 0, 0, 8'h08, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h18, 0);
        add(0, 0, 0,       1, 0, 1, 0, 8'h18, 0);
        add(0, 0, 0,       0, 0, 0, 0, 8'h18, 0);
        // burst UP, LEFT, DOWN; DOWN meets a full queue while a tick pops
        add(1, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 1, F_UP,    0, 1, 0, 0, 8'h00, 0);
        add(0, 1, F_LEFT,  0, 1, 0, 0, 8'h18, 0);
        add(0, 1, F_DOWN,  0, 1, 0, 0, 8'h08, 0);
        add(0, 0, 0,       1, 0, 1, 0, 8'h52, 0);
        add(0, 0, 0,       1, 3, 1, 0, 8'h52, 0);
        add(0, 0, 0,       1, 3, 0, 0, 8'h52, 0);
        add(0, 0, 0,       0, 3, 0, 0, 8'h52, 0);
        // invalid frames and an unmapped key
        add(1, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 1, F_BADC,  0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h00, 1);
        add(0, 0, 0,       1, 1, 0, 0, 8'h00, 1);
        add(0, 1, F_BADA,  0, 1, 0, 0, 8'h00, 1);
        add(0, 1, F_BADAN, 0, 1, 0, 0, 8'h00, 2);
        add(0, 1, F_OTHER, 0, 1, 0, 0, 8'h00, 3);
        add(0, 0, 0,       0, 1, 0, 0, 8'h45, 3);
        // pause: enter coincides with tick, keys dropped while paused
        add(1, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 1, F_UP,    0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h18, 0);
        add(0, 1, F_PAUSE, 0, 1, 0, 0, 8'h18, 0);
        add(0, 0, 0,       1, 1, 0, 1, 8'h1C, 0);
        add(0, 0, 0,       1, 1, 0, 1, 8'h1C, 0);
        add(0, 1, F_UP,    0, 1, 0, 1, 8'h1C, 0);
        add(0, 0, 0,       0, 1, 0, 1, 8'h18, 0);
        add(0, 1, F_PAUSE, 0, 1, 0, 1, 8'h18, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h1C, 0);
        add(0, 0, 0,       1, 1, 0, 0, 8'h1C, 0);
        // push into empty queue with a coincident tick is not popped by it
        add(0, 1, F_UP,    0, 1, 0, 0, 8'h1C, 0);
        add(0, 0, 0,       1, 1, 0, 0, 8'h18, 0);
        add(0, 0, 0,       1, 0, 1, 0, 8'h18, 0);
        add(0, 0, 0,       0, 0, 0, 0, 8'h18, 0);
        // reset while a frame is captured discards it
        add(0, 1, F_DOWN,  0, 0, 0, 0, 8'h18, 0);
        add(1, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0,       0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0,       1, 1, 0, 0, 8'h00, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset_n     = !tbl[i].rst;
            frame_valid = tbl[i].fv;
            word        = tbl[i].w;
            tick        = tbl[i].tk;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].h, tbl[i].tn, tbl[i].p,
                    tbl[i].lc, tbl[i].ec);
        end

        // Async reset mid-cycle with a frame in capture: outputs clear
        // immediately and the captured frame leaves no trace.
        cyc(1'b1, F_LEFT, 1'b0);
        cyc(1'b0, 0, 1'b0);
        chk("async pre lc", 32'(last_cmd), 32'h08);
        cyc(1'b1, F_UP, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk_all("async asserted", 2'd1, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0);
        chk_all("async after", 2'd1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Saturation: 301 bad frames total, counter stops at 255
        cyc(1'b1, F_BADC, 1'b0);
        cyc(1'b0, 0, 1'b0);
        chk("sat first", 32'(err_count), 32'd1);
        for (int k = 0; k < 300; k++)
            cyc(1'b1, F_BADC, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        chk_all("sat end", 2'd1, 1'b0, 1'b0, 8'h00, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
